// File: rtl/reset_sequencer.sv
// reset_sequencer: staggered multi-channel reset release with debounced manual reset and cause reporting.
module reset_sequencer #(
  parameter int CHANNELS = 3,
  parameter int HOLD = 4,
  parameter int STAGGER = 2,
  parameter int DEBOUNCE = 3,
  parameter int MANUAL_W = 21,
  parameter logic [MANUAL_W-1:0] MANUAL_MASK = 21'h10009
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MANUAL_W-1:0] manual,
  output logic [CHANNELS-1:0] rst_out,
  output logic                done,
  output logic [1:0]          cause
);
  localparam int CW = $clog2((HOLD > STAGGER ? HOLD : STAGGER) + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN, S_MANUAL} state_t;
  state_t state_q = S_HOLD, state_d;
  logic [CW-1:0] cnt_q = '0, cnt_d;
  logic [DW-1:0] deb_q = '0, deb_d;
  logic [MANUAL_W-1:0] sync1_q = '0, sync2_q = '0, sync1_d, sync2_d;
  logic level_q = 1'b0, level_d;
  logic [CHANNELS-1:0] rst_out_q = '1, rst_out_d, shifted;
  logic done_q = 1'b0, done_d;
  logic [1:0] cause_q = 2'd0, cause_d;
  logic combo, differ, toggle;
  always_comb begin
    combo = &(sync2_q & MANUAL_MASK | ~MANUAL_MASK);
    differ = combo != level_q;
    toggle = differ && deb_q == DW'(DEBOUNCE - 1);
    shifted = rst_out_q << 1;
    sync1_d = manual;
    sync2_d = sync1_q;
    deb_d = (toggle || !differ) ? '0 : deb_q + 1'b1;
    level_d = level_q ^ toggle;
    state_d = state_q;
    cnt_d = cnt_q;
    rst_out_d = rst_out_q;
    cause_d = cause_q;
    if (!rst_n) begin
      state_d = S_HOLD;
      cnt_d = '0;
      sync1_d = '0;
      sync2_d = '0;
      deb_d = '0;
      level_d = 1'b0;
      rst_out_d = '1;
      cause_d = 2'd1;
    end else if (toggle && !level_q) begin
      state_d = S_MANUAL;
      cnt_d = '0;
      rst_out_d = '1;
      cause_d = 2'd2;
    end else if (toggle && state_q == S_MANUAL) begin
      // the accepting edge itself is the first counted hold cycle
      state_d = S_HOLD;
      cnt_d = CW'(1);
    end else if (state_q == S_HOLD) begin
      cnt_d = cnt_q == CW'(HOLD) ? '0 : cnt_q + 1'b1;
      rst_out_d = cnt_q == CW'(HOLD) ? shifted : rst_out_q;
      state_d = cnt_q != CW'(HOLD) ? S_HOLD : shifted == '0 ? S_RUN : S_RELEASE;
    end else if (state_q == S_RELEASE) begin
      cnt_d = cnt_q == CW'(STAGGER - 1) ? '0 : cnt_q + 1'b1;
      rst_out_d = cnt_q == CW'(STAGGER - 1) ? shifted : rst_out_q;
      state_d = cnt_q == CW'(STAGGER - 1) && shifted == '0 ? S_RUN : S_RELEASE;
    end
    done_d = state_d == S_RUN;
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q <= cnt_d;
    deb_q <= deb_d;
    sync1_q <= sync1_d;
    sync2_q <= sync2_d;
    level_q <= level_d;
    rst_out_q <= rst_out_d;
    done_q <= done_d;
    cause_q <= cause_d;
  end
  assign rst_out = rst_out_q;
  assign done = done_q;
  assign cause = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of power-on, external, manual and parameter-sweep release timing.
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [20:0] manual = '0;
  logic [20:0] idle = '0;
  logic [2:0] r0;
  logic [0:0] r1;
  logic [7:0] r2;
  logic d0, d1, d2;
  logic [1:0] c0, c1, c2;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  reset_sequencer u0 (.clk(clk), .rst_n(rst_n), .manual(manual), .rst_out(r0), .done(d0), .cause(c0));
  reset_sequencer #(.CHANNELS(1), .HOLD(1), .STAGGER(1), .DEBOUNCE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .manual(idle), .rst_out(r1), .done(d1), .cause(c1));
  reset_sequencer #(.CHANNELS(8), .HOLD(100), .STAGGER(7)) u2 (
    .clk(clk), .rst_n(rst_n), .manual(idle), .rst_out(r2), .done(d2), .cause(c2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] exp_rst(input int k, input int c, input int h, input int s);
    logic [7:0] r = '0;
    for (int i = 0; i < c; i++) r[i] = k < h + i * s;
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic release_chk(input string tag);
    manual = '0;
    for (int k = 0; k <= 12; k++) begin
      step();
      chk({tag, "_rst"}, 32'(r0), k < 4 ? 32'h7 : 32'(exp_rst(k - 4, 3, 4, 2)));
      chk({tag, "_done"}, 32'(d0), 32'(k >= 12));
      chk({tag, "_cause"}, 32'(c0), 32'd2);
    end
  endtask
  task automatic ext_reset();
    rst_n = 1'b0;
    step();
    chk("ext_rst", 32'(r0), 32'h7);
    chk("ext_done", 32'(d0), 32'd0);
    chk("ext_cause", 32'(c0), 32'd1);
    rst_n = 1'b1;
  endtask
  initial begin
    #1;
    chk("init_rst", 32'(r0), 32'h7);
    chk("init_done", 32'(d0), 32'd0);
    chk("init_cause", 32'(c0), 32'd0);
    for (int k = 0; k <= 155; k++) begin
      step();
      if (k <= 9) begin
        chk("pon_rst", 32'(r0), 32'(exp_rst(k, 3, 4, 2)));
        chk("pon_done", 32'(d0), 32'(k >= 8));
        chk("pon_cause", 32'(c0), 32'd0);
      end
      chk("sw1_rst", 32'(r1), 32'(exp_rst(k, 1, 1, 1)));
      chk("sw1_done", 32'(d1), 32'(k >= 1));
      chk("sw8_rst", 32'(r2), 32'(exp_rst(k, 8, 100, 7)));
      chk("sw8_done", 32'(d2), 32'(k >= 149));
    end
    ext_reset();
    for (int k = 0; k <= 9; k++) begin
      step();
      chk("rel_rst", 32'(r0), 32'(exp_rst(k, 3, 4, 2)));
      chk("rel_done", 32'(d0), 32'(k >= 8));
      chk("rel_cause", 32'(c0), 32'd1);
    end
    manual = 21'h10009;
    for (int k = 0; k <= 9; k++) begin
      step();
      chk("man_rst", 32'(r0), k >= 4 ? 32'h7 : 32'h0);
      chk("man_done", 32'(d0), 32'(k < 4));
      chk("man_cause", 32'(c0), k >= 4 ? 32'd2 : 32'd1);
    end
    release_chk("man_rel");
    manual = 21'h10009;
    for (int k = 0; k <= 21; k++) begin
      step();
      if (k == 1) manual = 21'h10001;
      chk("glitch_rst", 32'(r0), 32'h0);
      chk("glitch_done", 32'(d0), 32'd1);
      chk("glitch_cause", 32'(c0), 32'd2);
    end
    manual = '0;
    step();
    ext_reset();
    for (int k = 0; k <= 9; k++) begin
      step();
      chk("late_rst", 32'(r0), k == 9 ? 32'h7 : 32'(exp_rst(k, 3, 4, 2)));
      chk("late_done", 32'(d0), 32'(k == 8));
      chk("late_cause", 32'(c0), k == 9 ? 32'd2 : 32'd1);
      if (k == 4) manual = 21'h10009;
    end
    ext_reset();
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("held_rst", 32'(r0), 32'h7);
      chk("held_cause", 32'(c0), k == 5 ? 32'd2 : 32'd1);
    end
    release_chk("held_rel");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
